// File: rtl/sample_readout.sv
// sample_readout
//
// Streams one full capture buffer out of a BRAM. On a rising edge of start
// (while idle) the oldest-sample address is latched and SAMPLE_DEPTH reads are
// issued in circular address order. Read data returns two cycles after each
// read strobe. It lands in a four-entry output FIFO that drives a valid/ready
// stream. Reads are throttled so that reads in flight plus FIFO occupancy
// never exceed four. A full downstream stall therefore never loses a sample.
//
// Ports
//   clk           system clock, rising-edge active
//   rst_n         synchronous active-low reset
//   start         readout request, rising edge acts (ignored while not idle)
//   read_pointer  address of the oldest captured sample
//   busy          high while a readout is in progress
//   done          one-cycle pulse after the final sample is accepted
//   bram_addr     read address to the capture memory
//   bram_en       read strobe to the capture memory
//   bram_data     read data, valid two cycles after the bram_en cycle
//   m_data        stream data (FIFO head)
//   m_valid       stream data valid
//   m_ready       downstream accept
//   m_last        marks the final sample of a readout

module sample_readout #(
    parameter int unsigned SAMPLE_DEPTH = 1024,
    parameter int unsigned SAMPLE_WIDTH = 8,
    localparam int unsigned ADDR_WIDTH = $clog2(SAMPLE_DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   read_pointer,
    output logic                    busy,
    output logic                    done,
    output logic [ADDR_WIDTH-1:0]   bram_addr,
    output logic                    bram_en,
    input  logic [SAMPLE_WIDTH-1:0] bram_data,
    output logic [SAMPLE_WIDTH-1:0] m_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic                    m_last
);

    // Counters carry one extra bit so that the value SAMPLE_DEPTH is reachable.
    localparam int unsigned CntWidth = ADDR_WIDTH + 1;
    localparam logic [CntWidth-1:0] DepthCnt = CntWidth'(SAMPLE_DEPTH);
    localparam logic [CntWidth-1:0] LastCnt  = CntWidth'(SAMPLE_DEPTH - 1);
    localparam logic [2:0]          FifoSlots = 3'd4;

    typedef enum logic [1:0] {
        StIdle,
        StReading,
        StDone
    } state_e;

    state_e                  state_q, state_d;
    logic                    prev_start_q;
    logic [ADDR_WIDTH-1:0]   base_q, base_d;
    logic [CntWidth-1:0]     issue_cnt_q, issue_cnt_d;
    logic [CntWidth-1:0]     send_cnt_q, send_cnt_d;

    // Read-return tracking: bit 0 = strobe issued last cycle,
    // bit 1 = bram_data carries a requested sample this cycle.
    logic [1:0]              rd_pipe_q, rd_pipe_d;

    logic [SAMPLE_WIDTH-1:0] fifo_mem_q [4];
    logic [1:0]              fifo_wr_ptr_q, fifo_wr_ptr_d;
    logic [1:0]              fifo_rd_ptr_q, fifo_rd_ptr_d;
    logic [2:0]              fifo_cnt_q, fifo_cnt_d;

    logic                    start_edge;
    logic                    fifo_push;
    logic                    fifo_pop;
    logic [2:0]              pending;

    // ------------------------------------------------------------------
    // Combinational status and stream outputs
    // ------------------------------------------------------------------

    assign start_edge = start & ~prev_start_q;
    assign fifo_push  = rd_pipe_q[1];
    assign fifo_pop   = m_valid & m_ready;

    // Every issued sample still owed to the stream: returning reads plus
    // buffered data. Capping this at four keeps the FIFO from overflowing.
    assign pending = fifo_cnt_q + {2'b00, rd_pipe_q[0]} + {2'b00, rd_pipe_q[1]};

    assign bram_en   = (state_q == StReading) && (issue_cnt_q < DepthCnt) &&
                       (pending < FifoSlots);
    // Natural wrap of the ADDR_WIDTH-bit sum gives the circular address.
    assign bram_addr = base_q + issue_cnt_q[ADDR_WIDTH-1:0];

    assign m_valid = (fifo_cnt_q != 3'd0);
    // Gated so the stream data reads zero whenever nothing is presented.
    assign m_data  = m_valid ? fifo_mem_q[fifo_rd_ptr_q] : '0;
    assign m_last  = m_valid && (send_cnt_q == LastCnt);

    assign busy = (state_q == StReading);
    assign done = (state_q == StDone);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        issue_cnt_d = issue_cnt_q + CntWidth'(bram_en);
        send_cnt_d  = send_cnt_q + CntWidth'(fifo_pop);

        unique case (state_q)
            StIdle: begin
                if (start_edge) begin
                    base_d      = read_pointer;
                    issue_cnt_d = '0;
                    send_cnt_d  = '0;
                    state_d     = StReading;
                end
            end
            StReading: begin
                if (fifo_pop && m_last) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        rd_pipe_d     = {rd_pipe_q[0], bram_en};
        fifo_wr_ptr_d = fifo_wr_ptr_q + 2'(fifo_push);
        fifo_rd_ptr_d = fifo_rd_ptr_q + 2'(fifo_pop);
        fifo_cnt_d    = fifo_cnt_q;
        unique case ({fifo_push, fifo_pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 3'd1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 3'd1;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            prev_start_q  <= 1'b0;
            base_q        <= '0;
            issue_cnt_q   <= '0;
            send_cnt_q    <= '0;
            rd_pipe_q     <= '0;
            fifo_wr_ptr_q <= '0;
            fifo_rd_ptr_q <= '0;
            fifo_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            prev_start_q  <= start;
            base_q        <= base_d;
            issue_cnt_q   <= issue_cnt_d;
            send_cnt_q    <= send_cnt_d;
            rd_pipe_q     <= rd_pipe_d;
            fifo_wr_ptr_q <= fifo_wr_ptr_d;
            fifo_rd_ptr_q <= fifo_rd_ptr_d;
            fifo_cnt_q    <= fifo_cnt_d;
        end
    end

    // Storage needs no reset: only entries counted in fifo_cnt_q are visible.
    always_ff @(posedge clk) begin
        if (rst_n && fifo_push) begin
            fifo_mem_q[fifo_wr_ptr_q] <= bram_data;
        end
    end

endmodule

// File: tb/tb_sample_readout.sv
module tb_sample_readout;

    localparam int DEPTH = 8;
    localparam int W     = 8;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] read_pointer;
    logic          busy;
    logic          done;
    logic [AW-1:0] bram_addr;
    logic          bram_en;
    logic [W-1:0]  bram_data;
    logic [W-1:0]  m_data;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic          m_last;

    sample_readout #(
        .SAMPLE_DEPTH(DEPTH),
        .SAMPLE_WIDTH(W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .read_pointer(read_pointer),
        .busy        (busy),
        .done        (done),
        .bram_addr   (bram_addr),
        .bram_en     (bram_en),
        .bram_data   (bram_data),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_last      (m_last)
    );

    always #5 clk = ~clk;

    // Capture memory with two-cycle read latency.
    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] bram_d1;
    always @(posedge clk) begin
        bram_d1   <= bram_en ? mem[bram_addr] : '0;
        bram_data <= bram_d1;
    end

    // Downstream ready: 0 = always, 1 = random 50%, 2 = stalled.
    int ready_mode = 0;
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = 1'($urandom_range(0, 1));
            default: m_ready = 1'b0;
        endcase
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: {last, data} per expected sample.
    logic [W:0] exp_q[$];

    int n_vec = 0;
    int n_err = 0;
    int pending = 0;
    int en_count = 0;
    int xfer_total = 0;
    int n_xfer_run = 0;
    int first_xfer = 0;
    int last_xfer = 0;
    int start_cyc = 0;
    bit exp_done = 0;
    bit after_done = 0;
    bit prev_stall = 0;
    logic [W-1:0] prev_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    initial begin
        logic [W:0] e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pending    = 0;
                exp_done   = 0;
                after_done = 0;
                prev_stall = 0;
            end else begin
                check("done_pulse", done, exp_done);
                if (exp_done)   check("busy_in_done", busy, 0);
                if (after_done) check("busy_after_done", busy, 0);
                after_done = exp_done;
                exp_done   = 0;
                if (prev_stall) begin
                    check("hold_valid", m_valid, 1);
                    check("hold_data", m_data, prev_data);
                end
                if (bram_en) begin
                    check("pending_below_4", pending < 4, 1);
                    pending++;
                    en_count++;
                end
                if (!m_valid) check("last_without_valid", m_last, 0);
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL stray_sample: got %0h expected none (t=%0t)", m_data, $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("data", m_data, e[W-1:0]);
                        check("last", m_last, e[W]);
                        if (e[W]) exp_done = 1;
                    end
                    pending--;
                    xfer_total++;
                    if (n_xfer_run == 0) first_xfer = cyc;
                    last_xfer = cyc;
                    n_xfer_run++;
                end else if (m_valid && exp_q.size() > 0) begin
                    check("last_flag", m_last, exp_q[0][W]);
                end
                prev_stall = m_valid && !m_ready;
                prev_data  = m_data;
            end
        end
    end

    // Reference model: a readout yields DEPTH samples in circular order from rp.
    task automatic push_exp(input int rp);
        for (int i = 0; i < DEPTH; i++) begin
            exp_q.push_back({(i == DEPTH - 1), mem[(rp + i) % DEPTH]});
        end
    endtask

    task automatic start_readout(input int rp);
        read_pointer = AW'(rp);
        push_exp(rp);
        n_xfer_run = 0;
        start_cyc  = cyc;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0 && !busy && !done && !exp_done && !after_done) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL readout_timeout: got %0d samples left expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_bram_en", bram_en, 0);
        check("rst_bram_addr", bram_addr, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_last", m_last, 0);
        check("rst_m_data", m_data, 0);
    endtask

    task automatic fill_random();
        for (int i = 0; i < DEPTH; i++) mem[i] = W'($urandom);
    endtask

    initial begin
        int en0;
        int n0;
        rst_n = 1'b0;
        start = 1'b0;
        read_pointer = '0;
        for (int i = 0; i < DEPTH; i++) mem[i] = W'(i);
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Straight readout from 0, full-rate stream.
        ready_mode = 0;
        start_readout(0);
        check("busy_reading", busy, 1);
        wait_idle();
        check("first_latency_le4", (first_xfer - start_cyc) <= 4, 1);
        check("burst_cycles", last_xfer - first_xfer, DEPTH - 1);

        // Wrapped readout from 5.
        start_readout(5);
        check("busy_reading2", busy, 1);
        wait_idle();
        check("burst_cycles_wrap", last_xfer - first_xfer, DEPTH - 1);

        // Random backpressure with a long stall.
        fill_random();
        ready_mode = 1;
        start_readout(int'($urandom_range(0, DEPTH - 1)));
        repeat (3) @(posedge clk);
        ready_mode = 2;
        repeat (20) @(posedge clk);
        #2;
        check("valid_after_stall", m_valid, 1);
        ready_mode = 1;
        wait_idle();

        // Start edge during a readout is ignored; a later one restarts.
        ready_mode = 0;
        start_readout(2);
        repeat (2) @(posedge clk);
        #1;
        read_pointer = 3'd6;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle();
        repeat (3) @(posedge clk);
        #1;
        check("no_restart", busy, 0);
        start_readout(6);
        wait_idle();

        // Reset after three transfers aborts cleanly.
        n0 = xfer_total;
        start_readout(1);
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (xfer_total >= n0 + 3) break;
        end
        rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        check_reset_outputs();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("no_valid_after_reset", m_valid, 0);
        end
        @(posedge clk);
        #1;

        // Stalled from the start: exactly four reads go out.
        ready_mode = 2;
        en0 = en_count;
        start_readout(4);
        repeat (14) @(posedge clk);
        #1;
        check("en_pulses_stalled", en_count - en0, 4);
        check("valid_stalled", m_valid, 1);
        ready_mode = 0;
        wait_idle();

        // Start held high through reset release counts as an edge.
        rst_n = 1'b0;
        start = 1'b1;
        read_pointer = 3'd3;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        push_exp(3);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle();

        // Random readouts.
        for (int k = 0; k < 6; k++) begin
            fill_random();
            ready_mode = int'($urandom_range(0, 1));
            start_readout(int'($urandom_range(0, DEPTH - 1)));
            wait_idle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
